// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BI, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop, with a start/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BO,
    output logic             OVF
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;

    // Full-subtractor cell on the current LSBs and the borrow flop.
    always_comb begin
        a_bit   = opa[0];
        b_bit   = opb[0];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            DIFF  <= '0;
            BO    <= 1'b0;
            OVF   <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        br    <= BI;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    br  <= br_next;
                    res <= {d_bit, res[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    // Last bit: br is the borrow into the MSB, br_next the borrow out.
                    if (cnt == CW'(WIDTH - 1)) begin
                        DIFF  <= {d_bit, res[WIDTH-1:1]};
                        BO    <= br_next;
                        OVF   <= br ^ br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
